// File: rtl/char_pixel_renderer_if.sv
// Scan-position, text-write and glyph-array signals of the character pixel renderer.
// The master side is the surrounding system (timing generator, CPU, glyph memory); the slave is the renderer.
interface char_pixel_renderer_if #(
  parameter int AW = 6
);
  logic [9:0]    hpos;
  logic [9:0]    vpos;
  logic          active;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;
  logic [1:0]    glyph_x;
  logic [2:0]    glyph_y;
  logic [35:0]   glyph_bits;
  logic          pixel_out;
  logic          active_out;

  modport master (
    output hpos, vpos, active, wr_en, wr_addr, wr_data, glyph_bits,
    input  glyph_x, glyph_y, pixel_out, active_out
  );

  modport slave (
    input  hpos, vpos, active, wr_en, wr_addr, wr_data, glyph_bits,
    output glyph_x, glyph_y, pixel_out, active_out
  );
endinterface

// File: rtl/char_pixel_renderer.sv
// Text-mode pixel renderer: walks character cells with carry-chained counters, looks up the
// character code, addresses the glyph array and emits one pixel per clock, two cycles behind hpos.
module char_pixel_renderer #(
  parameter int COLS  = 16,
  parameter int ROWS  = 4,
  parameter int SCALE = 2,
  parameter int AW    = 6
) (
  input  logic                  clock,
  input  logic                  rst_n,
  char_pixel_renderer_if.slave  bus
);

  localparam int NCELL = COLS * ROWS;
  localparam int NENT  = 1 << AW;
  localparam int CW    = $clog2(COLS + 1);
  localparam int RW    = $clog2(ROWS + 1);

  logic [5:0]    buffer [NENT];

  logic [2:0]    sx_r, gx_r, sy_r, gy_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [2:0]    sx_c, gx_c, sy_c, gy_c;
  logic [CW-1:0] col_c;
  logic [RW-1:0] row_c;

  logic          line_start, in_text, visible, ink;
  logic [AW-1:0] rd_addr;

  logic [5:0]    code_p1;
  logic          vis_p1, vld_p1;

  assign line_start = bus.active && (bus.hpos == 10'd0);

  // Registers hold the previous pixel's position; these are the current pixel's.
  always_comb begin
    sx_c  = '0;
    gx_c  = '0;
    col_c = '0;
    if (bus.hpos != 10'd0) begin
      sx_c  = sx_r;
      gx_c  = gx_r;
      col_c = col_r;
      if (32'(sx_r) == SCALE - 1) begin
        sx_c = '0;
        if (gx_r == 3'd4) begin
          gx_c = '0;
          if (32'(col_r) < COLS) col_c = col_r + 1'b1;
        end else begin
          gx_c = gx_r + 3'd1;
        end
      end else begin
        sx_c = sx_r + 3'd1;
      end
    end
  end

  always_comb begin
    sy_c  = sy_r;
    gy_c  = gy_r;
    row_c = row_r;
    if (line_start) begin
      if (bus.vpos == 10'd0) begin
        sy_c  = '0;
        gy_c  = '0;
        row_c = '0;
      end else if (32'(sy_r) == SCALE - 1) begin
        sy_c = '0;
        if (gy_r == 3'd5) begin
          gy_c = '0;
          if (32'(row_r) < ROWS) row_c = row_r + 1'b1;
        end else begin
          gy_c = gy_r + 3'd1;
        end
      end else begin
        sy_c = sy_r + 3'd1;
      end
    end
  end

  always_comb begin
    in_text = (32'(col_c) < COLS) && (32'(row_c) < ROWS);
    visible = bus.active && in_text && (gx_c < 3'd4) && (gy_c < 3'd5);
    rd_addr = in_text ? AW'(int'(row_c) * COLS + int'(col_c)) : '0;
    ink     = (code_p1 < 6'd36) ? bus.glyph_bits[code_p1] : 1'b0;
  end

  // Text buffer: a write lands at the edge, so a same-edge read sees the old code.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) buffer[i] <= 6'd63;
    end else if (bus.wr_en && (32'(bus.wr_addr) < NCELL)) begin
      buffer[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stage 1: counters advance, glyph address and character code registered
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sx_r        <= '0;
      gx_r        <= '0;
      col_r       <= '0;
      sy_r        <= '0;
      gy_r        <= '0;
      row_r       <= '0;
      bus.glyph_x <= '0;
      bus.glyph_y <= '0;
      code_p1     <= '0;
      vis_p1      <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      sx_r    <= sx_c;
      gx_r    <= gx_c;
      col_r   <= col_c;
      sy_r    <= sy_c;
      gy_r    <= gy_c;
      row_r   <= row_c;
      // Gap column/row hold the last ink address so the glyph array sees no extra toggles.
      if (gx_c != 3'd4) bus.glyph_x <= gx_c[1:0];
      if (gy_c != 3'd5) bus.glyph_y <= gy_c;
      code_p1 <= buffer[rd_addr];
      vis_p1  <= visible;
      vld_p1  <= bus.active;
    end
  end

  // Stage 2: pick the character's bit from the glyph slice
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.pixel_out  <= 1'b0;
      bus.active_out <= 1'b0;
    end else begin
      bus.pixel_out  <= vis_p1 && ink;
      bus.active_out <= vld_p1;
    end
  end

endmodule

// File: tb/tb_char_pixel_renderer.sv
// Directed bench for char_pixel_renderer: scripted scan lines against a behavioural glyph memory
// and a position-arithmetic reference for the expected pixels.
module tb_char_pixel_renderer;

  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int SCALE = 2;
  localparam int AW    = 7;
  localparam int NH    = 180;
  localparam int ACT_W = 170;
  localparam int NV    = 52;

  logic clock = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   glyph_mode = 0;
  logic [5:0] shadow [COLS*ROWS];

  always #5 clock = ~clock;

  char_pixel_renderer_if #(.AW(AW)) bus ();

  char_pixel_renderer #(.COLS(COLS), .ROWS(ROWS), .SCALE(SCALE), .AW(AW)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Mode 0: every glyph solid. Mode 1: real 'A', other characters a checkerboard.
  function automatic logic glyph_model(int mode, int code, int x, int y);
    logic [3:0] r;
    if (mode == 0) return 1'b1;
    if (code == 0) begin
      case (y)
        0:       r = 4'b0110;
        1:       r = 4'b1001;
        2:       r = 4'b1111;
        default: r = 4'b1001;
      endcase
      return r[3-x];
    end
    return ((code + x + y) % 2) == 1;
  endfunction

  always_comb begin
    bus.glyph_bits = '0;
    for (int i = 0; i < 36; i++)
      bus.glyph_bits[i] = glyph_model(glyph_mode, i, int'(bus.glyph_x), int'(bus.glyph_y));
  end

  function automatic logic exp_pix(int h, int v);
    int col, gx, row, gy, code;
    if (h >= ACT_W) return 1'b0;
    col = h / (5 * SCALE);
    gx  = (h / SCALE) % 5;
    row = v / (6 * SCALE);
    gy  = (v / SCALE) % 6;
    if (col >= COLS || row >= ROWS || gx == 4 || gy == 5) return 1'b0;
    code = int'(shadow[row*COLS + col]);
    if (code >= 36) return 1'b0;
    return glyph_model(glyph_mode, code, gx, gy);
  endfunction

  function automatic logic [NH-1:0] exp_line(int v);
    logic [NH-1:0] e;
    for (int h = 0; h < NH; h++) e[h] = exp_pix(h, v);
    return e;
  endfunction

  function automatic logic [NH-1:0] act_line();
    logic [NH-1:0] e;
    for (int h = 0; h < NH; h++) e[h] = (h < ACT_W);
    return e;
  endfunction

  task automatic drive(input int h, input int v, input logic a);
    bus.hpos   = 10'(h);
    bus.vpos   = 10'(v);
    bus.active = a;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clock);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = 6'(d);
    drive(300, 0, 1'b0);
    @(negedge clock);
    bus.wr_en = 1'b0;
    if (a < COLS*ROWS) shadow[a] = 6'(d);
  endtask

  // Drives one scan line; pix[h]/act[h] are the outputs belonging to hpos h.
  task automatic run_line(input int v, output logic [NH-1:0] pix, output logic [NH-1:0] act);
    for (int k = 0; k < NH + 2; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        pix[k-2] = bus.pixel_out;
        act[k-2] = bus.active_out;
      end
      drive(k, v, k < ACT_W);
    end
  endtask

  task automatic test_reset();
    logic [NH-1:0] pix, act;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    drive(0, 0, 1'b1);
    for (int i = 0; i < COLS*ROWS; i++) shadow[i] = 6'd63;
    glyph_mode = 0;
    #3;
    n_tests++; if (bus.glyph_x !== 2'd0) begin n_fail++; $display("FAIL reset_glyph_x got %0d want 0", bus.glyph_x); end
    n_tests++; if (bus.glyph_y !== 3'd0) begin n_fail++; $display("FAIL reset_glyph_y got %0d want 0", bus.glyph_y); end
    repeat (3) @(negedge clock);
    n_tests++; if (bus.pixel_out !== 1'b0) begin n_fail++; $display("FAIL reset_pixel got %b want 0", bus.pixel_out); end
    n_tests++; if (bus.active_out !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", bus.active_out); end
    rst_n = 1'b1;
    for (int v = 0; v < NV; v++) begin
      run_line(v, pix, act);
      n_tests++; if (pix !== '0) begin n_fail++; $display("FAIL blank_frame v=%0d got %h want 0", v, pix); end
      n_tests++; if (act !== act_line()) begin n_fail++; $display("FAIL active_delay v=%0d got %h want %h", v, act, act_line()); end
    end
  endtask

  task automatic test_glyph_a();
    logic [1:0] gxs [13];
    logic       po  [13];
    logic [9:0] a_row0;
    a_row0 = 10'b0000111100;   // bit h: A row 0 (0110) doubled, then gap
    wr(0, 0);
    glyph_mode = 1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      gxs[k] = bus.glyph_x;
      po[k]  = bus.pixel_out;
      drive(k, 0, 1'b1);
    end
    for (int t = 0; t < 10; t++) begin
      n_tests++;
      if (gxs[t+1] !== 2'((t < 8) ? t / 2 : 3)) begin
        n_fail++; $display("FAIL glyph_x h=%0d got %0d want %0d", t, gxs[t+1], (t < 8) ? t / 2 : 3);
      end
      n_tests++;
      if (po[t+2] !== a_row0[t]) begin
        n_fail++; $display("FAIL a_row0 h=%0d got %b want %b", t, po[t+2], a_row0[t]);
      end
    end
  endtask

  task automatic test_code5();
    logic [NH-1:0] pix, act, hv;
    glyph_mode = 0;
    for (int a = 0; a < COLS*ROWS; a++) wr(a, 5);
    for (int h = 0; h < NH; h++) hv[h] = (h < 160) && (((h / 2) % 5) != 4);
    for (int v = 0; v < NV; v++) begin
      run_line(v, pix, act);
      n_tests++; if (pix !== exp_line(v)) begin n_fail++; $display("FAIL code5 v=%0d got %h want %h", v, pix, exp_line(v)); end
      if (v == 0) begin
        n_tests++; if (pix !== hv) begin n_fail++; $display("FAIL code5_row0 got %h want %h", pix, hv); end
      end
      if (v == 10 || v == 11 || v >= 48) begin
        n_tests++; if (pix !== '0) begin n_fail++; $display("FAIL code5_gap v=%0d got %h want 0", v, pix); end
      end
    end
  endtask

  task automatic test_code_range();
    logic [NH-1:0] pix, act;
    wr(1, 35); wr(2, 36); wr(3, 63);
    run_line(0, pix, act);
    n_tests++; if (pix[17:10] !== 8'hFF) begin n_fail++; $display("FAIL code35 got %h want ff", pix[17:10]); end
    n_tests++; if (pix[39:20] !== 20'h0) begin n_fail++; $display("FAIL code36_63 got %h want 0", pix[39:20]); end
    n_tests++; if (pix !== exp_line(0)) begin n_fail++; $display("FAIL code_range got %h want %h", pix, exp_line(0)); end
  endtask

  task automatic test_back_to_back();
    logic [NH-1:0] pix, act;
    wr(0, 0);
    for (int k = 0; k < NH + 2; k++) begin
      @(negedge clock);
      if (k >= 2) pix[k-2] = bus.pixel_out;
      bus.wr_en   = (k == 0);
      bus.wr_addr = '0;
      bus.wr_data = 6'd63;
      drive(k, 0, k < ACT_W);
    end
    bus.wr_en = 1'b0;
    shadow[0] = 6'd63;
    n_tests++; if (pix[0] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_old got %b want 1", pix[0]); end
    n_tests++; if (pix[1] !== 1'b0) begin n_fail++; $display("FAIL same_cycle_new got %b want 0", pix[1]); end
    run_line(1, pix, act);
    n_tests++; if (pix !== exp_line(1)) begin n_fail++; $display("FAIL next_pass got %h want %h", pix, exp_line(1)); end
    wr(64, 0); wr(127, 0);
    run_line(0, pix, act);
    n_tests++; if (pix[9:0] !== 10'h0) begin n_fail++; $display("FAIL out_of_range got %h want 0", pix[9:0]); end
    n_tests++; if (pix !== exp_line(0)) begin n_fail++; $display("FAIL out_of_range_line got %h want %h", pix, exp_line(0)); end
  endtask

  task automatic test_mid_reset();
    logic [NH-1:0] pix, act;
    for (int v = 0; v < 20; v++) run_line(v, pix, act);
    for (int k = 0; k <= 200; k++) begin
      @(negedge clock);
      drive(k, 20, 1'b1);
    end
    n_tests++; if (bus.active_out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_active got %b want 1", bus.active_out); end
    n_tests++; if (bus.glyph_y !== 3'd4) begin n_fail++; $display("FAIL pre_reset_glyph_y got %0d want 4", bus.glyph_y); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.pixel_out !== 1'b0) begin n_fail++; $display("FAIL async_pixel got %b want 0", bus.pixel_out); end
    n_tests++; if (bus.active_out !== 1'b0) begin n_fail++; $display("FAIL async_active got %b want 0", bus.active_out); end
    n_tests++; if (bus.glyph_y !== 3'd0) begin n_fail++; $display("FAIL async_glyph_y got %0d want 0", bus.glyph_y); end
    @(negedge clock);
    drive(201, 20, 1'b1);
    @(negedge clock);
    n_tests++; if (bus.active_out !== 1'b0) begin n_fail++; $display("FAIL held_reset_active got %b want 0", bus.active_out); end
    n_tests++; if (bus.glyph_x !== 2'd0) begin n_fail++; $display("FAIL held_reset_glyph_x got %0d want 0", bus.glyph_x); end
    rst_n = 1'b1;
    for (int i = 0; i < COLS*ROWS; i++) shadow[i] = 6'd63;
    glyph_mode = 0;
    run_line(0, pix, act);
    n_tests++; if (pix !== '0) begin n_fail++; $display("FAIL buffer_blank got %h want 0", pix); end
    glyph_mode = 1;
    wr(0, 0); wr(1, 7); wr(2, 26); wr(16, 3); wr(17, 35);
    for (int v = 0; v < 26; v++) begin
      run_line(v, pix, act);
      n_tests++; if (pix !== exp_line(v)) begin n_fail++; $display("FAIL post_reset v=%0d got %h want %h", v, pix, exp_line(v)); end
    end
  endtask

  initial begin
    test_reset();
    test_glyph_a();
    test_code5();
    test_code_range();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
